// File: rtl/vec_pkg.sv
// Shared lane-count, lane-index type and float constants for the vec3 pack path.
package vec_pkg;

   localparam int VEC_LANES = 3;

   typedef logic [1:0] lane_idx_t;

   localparam lane_idx_t LANE_FIRST = 2'd0;
   localparam lane_idx_t LANE_LAST  = 2'd2;

   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/vec_pack.sv
// Gathers a scalar AXI-stream into 3-lane vectors behind a one-slot output register.
// Optional early vector close via tlast when VEC_PACK_LAST_EN is defined.
module vec_pack
   import vec_pkg::*;
#(
   parameter int SIZE = 32
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [SIZE-1:0]      s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
`ifdef VEC_PACK_LAST_EN
   input  logic                 s_axis_tlast,
   output logic                 m_axis_result_tlast,
`endif
   output logic [2:0][SIZE-1:0] m_axis_result_tdata,
   output logic                 m_axis_result_tvalid,
   input  logic                 m_axis_result_tready
);

   lane_idx_t                         idx_q, idx_d;
   logic [SIZE-1:0]                   g0_q, g0_d;
   logic [SIZE-1:0]                   g1_q, g1_d;
   logic [VEC_LANES-1:0][SIZE-1:0]    out_q, out_d;
   logic                              out_v_q, out_v_d;
   logic                              rst_done_q;

   logic                              s_last;
   logic                              s_fire;
   logic                              m_fire;
   logic                              close_vec;
   logic [VEC_LANES-1:0][SIZE-1:0]    held;
   logic [VEC_LANES-1:0][SIZE-1:0]    lanes;

`ifdef VEC_PACK_LAST_EN
   logic                              last_q, last_d;

   assign s_last = s_axis_tlast;
   assign m_axis_result_tlast = last_q;
`else
   assign s_last = 1'b0;
`endif

   // Only the word that would close a vector has to wait for the output slot.
   assign s_axis_tready = rst_done_q & ~(out_v_q & ((idx_q == LANE_LAST) | s_last));
   assign s_fire        = s_axis_tvalid & s_axis_tready;
   assign m_fire        = out_v_q & m_axis_result_tready;
   assign close_vec     = s_fire & ((idx_q == LANE_LAST) | s_last);

   assign held = {{SIZE{1'b0}}, g1_q, g0_q};

   // Lanes below idx come from the gather regs, lane idx is the incoming word, lanes above are zero.
   genvar gi;
   generate
      for (gi = 0; gi < VEC_LANES; gi++) begin : g_lane
         assign lanes[gi] = (lane_idx_t'(gi) == idx_q) ? s_axis_tdata :
                            (lane_idx_t'(gi) <  idx_q) ? held[gi]     : {SIZE{1'b0}};
      end
   endgenerate

   always_comb begin
      idx_d   = idx_q;
      g0_d    = g0_q;
      g1_d    = g1_q;
      out_d   = out_q;
      out_v_d = out_v_q;
`ifdef VEC_PACK_LAST_EN
      last_d  = last_q;
`endif
      if (m_fire) begin
         out_v_d = 1'b0;
      end
      if (s_fire) begin
         if (close_vec) begin
            out_d   = lanes;
            out_v_d = 1'b1;
            idx_d   = LANE_FIRST;
`ifdef VEC_PACK_LAST_EN
            last_d  = s_last;
`endif
         end else begin
            if (idx_q == LANE_FIRST) begin
               g0_d = s_axis_tdata;
            end else begin
               g1_d = s_axis_tdata;
            end
            idx_d = lane_idx_t'(idx_q + 2'd1);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         idx_q      <= LANE_FIRST;
         g0_q       <= '0;
         g1_q       <= '0;
         out_q      <= '0;
         out_v_q    <= 1'b0;
         rst_done_q <= 1'b0;
`ifdef VEC_PACK_LAST_EN
         last_q     <= 1'b0;
`endif
      end else begin
         idx_q      <= idx_d;
         g0_q       <= g0_d;
         g1_q       <= g1_d;
         out_q      <= out_d;
         out_v_q    <= out_v_d;
         rst_done_q <= 1'b1;
`ifdef VEC_PACK_LAST_EN
         last_q     <= last_d;
`endif
      end
   end

   assign m_axis_result_tdata  = out_q;
   assign m_axis_result_tvalid = out_v_q;

endmodule

// File: tb/tb_vec_pack.sv
// Randomised and directed bench for vec_pack against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_vec_pack;
   import vec_pkg::*;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic [31:0]      s_data = '0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic             s_last = 1'b0;
   logic [2:0][31:0] m_data;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic             m_last;

   always #5 aclk = ~aclk;

   vec_pack #(.SIZE(32)) dut (
      .aclk                 (aclk),
      .aresetn              (aresetn),
      .s_axis_tdata         (s_data),
      .s_axis_tvalid        (s_valid),
      .s_axis_tready        (s_ready),
`ifdef VEC_PACK_LAST_EN
      .s_axis_tlast         (s_last),
      .m_axis_result_tlast  (m_last),
`endif
      .m_axis_result_tdata  (m_data),
      .m_axis_result_tvalid (m_valid),
      .m_axis_result_tready (m_ready)
   );

`ifndef VEC_PACK_LAST_EN
   assign m_last = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   // Model: words gathered so far, vectors waiting in the output slot, vectors seen leaving.
   logic [31:0] part [3];
   int          cnt = 0;
   bit          rst_done = 1'b0;
   logic [95:0] pend_q [$];
   bit          pend_last_q [$];
   logic [95:0] got_q [$];

   logic [31:0] fw [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h40800000, 32'h40A00000, 32'h40C00000};

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit exp_ready(input bit lastin);
      return rst_done && !(pend_q.size() != 0 && (cnt == 2 || lastin));
   endfunction

   task automatic cycle(input bit v, input logic [31:0] d, input bit l, input bit mr, output bit acc);
      bit er, ev, sf, mf;
      logic [95:0] vec;
      @(negedge aclk);
      s_valid = v; s_data = d; s_last = l; m_ready = mr;
      #1;
      er = exp_ready(l);
      ev = (pend_q.size() != 0);
      chk("s_tready", {95'd0, s_ready}, {95'd0, er});
      chk("m_tvalid", {95'd0, m_valid}, {95'd0, ev});
      if (ev) begin
         chk("m_tdata", m_data, pend_q[0]);
`ifdef VEC_PACK_LAST_EN
         chk("m_tlast", {95'd0, m_last}, {95'd0, pend_last_q[0]});
`endif
      end
      sf = v && er;
      mf = ev && mr;
      if (mf) got_q.push_back(m_data);
      @(posedge aclk);
      #1;
      if (mf) begin
         void'(pend_q.pop_front());
         void'(pend_last_q.pop_front());
      end
      if (sf) begin
         part[cnt] = d;
         if (cnt == 2 || l) begin
            vec = {(cnt >= 2) ? part[2] : 32'h0, (cnt >= 1) ? part[1] : 32'h0, part[0]};
            pend_q.push_back(vec);
            pend_last_q.push_back(cnt != 2 || l);
            cnt = 0;
         end else begin
            cnt++;
         end
      end
      acc = sf;
   endtask

   task automatic do_reset(input int n);
      @(negedge aclk);
      aresetn = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      #1;
      cnt = 0; rst_done = 1'b0;
      pend_q.delete(); pend_last_q.delete(); got_q.delete();
      repeat (n) @(negedge aclk);
      #1;
      chk("rst_tvalid", {95'd0, m_valid}, 96'd0);
      chk("rst_tdata", m_data, 96'd0);
      chk("rst_tready", {95'd0, s_ready}, 96'd0);
`ifdef VEC_PACK_LAST_EN
      chk("rst_tlast", {95'd0, m_last}, 96'd0);
`endif
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      chk("rel_tready_low", {95'd0, s_ready}, 96'd0);
      @(posedge aclk);
      #1;
      rst_done = 1'b1;
      chk("rel_tready_high", {95'd0, s_ready}, 96'd1);
   endtask

   initial begin
      bit a;
      int k, guard, drops;
      logic [31:0] w [12];

      // Reset held 5 cycles
      do_reset(5);

      // Single vector 1.0, 2.0, 3.0
      got_q.delete();
      cycle(1, FP_ONE, 0, 1, a);
      cycle(1, 32'h40000000, 0, 1, a);
      cycle(1, 32'h40400000, 0, 1, a);
      chk("t2_latency", {95'd0, m_valid}, 96'd1);
      cycle(0, FP_ZERO, 0, 1, a);
      cycle(0, FP_ZERO, 0, 1, a);
      chk("t2_count", got_q.size(), 1);
      chk("t2_vec", (got_q.size() > 0) ? got_q[0] : 96'd0, 96'h40400000_40000000_3F800000);

      // 12 words back-to-back
      got_q.delete();
      drops = 0;
      for (int i = 0; i < 12; i++) begin
         w[i] = $urandom;
         cycle(1, w[i], 0, 1, a);
         if (!a) drops++;
      end
      cycle(0, FP_ZERO, 0, 1, a);
      cycle(0, FP_ZERO, 0, 1, a);
      chk("t3_drops", drops, 0);
      chk("t3_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_q.size())
            chk("t3_order", got_q[i], {w[3*i+2], w[3*i+1], w[3*i]});
      end

      // Backpressure with 6 words offered
      got_q.delete();
      k = 0;
      repeat (8) begin
         cycle(1, fw[k], 0, 0, a);
         if (a) k++;
      end
      chk("t4_accepted", k, 5);
      chk("t4_stall", {95'd0, s_ready}, 96'd0);
      chk("t4_hold", m_data, {fw[2], fw[1], fw[0]});
      guard = 0;
      while (got_q.size() < 2 && guard < 12) begin
         cycle(k < 6, fw[(k < 6) ? k : 0], 0, 1, a);
         if (a) k++;
         guard++;
      end
      chk("t4_count", got_q.size(), 2);
      chk("t4_vec0", (got_q.size() > 0) ? got_q[0] : 96'd0, {fw[2], fw[1], fw[0]});
      chk("t4_vec1", (got_q.size() > 1) ? got_q[1] : 96'd0, {fw[5], fw[4], fw[3]});

      // Reset mid-vector, then 3.0, 1.0, 2.0
      cycle(1, fw[3], 0, 1, a);
      cycle(1, fw[4], 0, 1, a);
      do_reset(2);
      cycle(1, 32'h40400000, 0, 1, a);
      cycle(1, FP_ONE, 0, 1, a);
      cycle(1, 32'h40000000, 0, 1, a);
      cycle(0, FP_ZERO, 0, 1, a);
      cycle(0, FP_ZERO, 0, 1, a);
      chk("t5_count", got_q.size(), 1);
      chk("t5_vec", (got_q.size() > 0) ? got_q[0] : 96'd0, 96'h40000000_3F800000_40400000);

`ifdef VEC_PACK_LAST_EN
      // Early close with tlast on lane 1
      got_q.delete();
      cycle(1, FP_ONE, 0, 1, a);
      cycle(1, 32'h40000000, 1, 1, a);
      chk("t6_tlast", {95'd0, m_last}, 96'd1);
      chk("t6_vec", m_data, 96'h00000000_40000000_3F800000);
      cycle(1, fw[2], 0, 1, a);
      cycle(1, fw[3], 0, 1, a);
      cycle(1, fw[4], 0, 1, a);
      chk("t6_next_tlast", {95'd0, m_last}, 96'd0);
      cycle(0, FP_ZERO, 0, 1, a);
      chk("t6_count", got_q.size(), 2);
      chk("t6_next_vec", (got_q.size() > 1) ? got_q[1] : 96'd0, {fw[4], fw[3], fw[2]});
`endif

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         bit rl;
`ifdef VEC_PACK_LAST_EN
         rl = ($urandom % 5 == 0);
`else
         rl = 1'b0;
`endif
         cycle(($urandom % 4) != 0, $urandom, rl, ($urandom % 3) != 0, a);
      end
      repeat (4) cycle(0, FP_ZERO, 0, 1, a);
      chk("rand_drained", pend_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
